power_spectrum: RTL and testbench

Streaming power-spectrum stage placed directly downstream of the FFT in the MFCC pipeline. It accepts one complex Q1.31 bin per cycle (32-bit signed real and imaginary parts) over a valid/ready handshake. For each bin it computes |X|² = re² + im² as an unsigned 64-bit value in a 3-stage pipeline. It tags each result with its bin index and frame-last flag for the mel filterbank that follows.

---
 rtl/power_spectrum.sv | 170 +++++++++++++++++
 tb/tb_power_spectrum.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_spectrum.sv
// Streaming |X|^2 stage behind the FFT: three register stages (capture, square, sum) with a shared stall.
// Optional build macro PSPEC_HALF_EN emits only bins 0..N_FFT/2 (the non-redundant half of a real-input FFT).
module power_spectrum #(
  parameter int N_FFT = 512,
  parameter int BIN_W = $clog2(N_FFT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_re,
  input  logic [31:0]      in_im,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_power,
  output logic [BIN_W-1:0] out_bin,
  output logic             out_last,
  output logic             frame_err,
  input  logic             frame_err_clr
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_FFT - 1);

  logic                    advance;
  logic                    in_xfer;
  logic                    cnt_wrap;
  logic                    len_err;
  logic                    keep_bin;
  logic                    tag_last;

  logic [BIN_W-1:0]        bin_cnt_q, bin_cnt_d;
  logic                    frame_err_q, frame_err_d;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [31:0]      s1_re_q, s1_re_d;
  logic signed [31:0]      s1_im_q, s1_im_d;
  logic [BIN_W-1:0]        s1_bin_q, s1_bin_d;
  logic                    s1_last_q, s1_last_d;

  logic                    s2_valid_q, s2_valid_d;
  logic [63:0]             s2_re_sq_q, s2_re_sq_d;
  logic [63:0]             s2_im_sq_q, s2_im_sq_d;
  logic [BIN_W-1:0]        s2_bin_q, s2_bin_d;
  logic                    s2_last_q, s2_last_d;

  logic                    s3_valid_q, s3_valid_d;
  logic [63:0]             s3_power_q, s3_power_d;
  logic [BIN_W-1:0]        s3_bin_q, s3_bin_d;
  logic                    s3_last_q, s3_last_d;

  // One stall signal for the whole pipe: it only stops when the result it is holding is refused.
  assign advance  = !s3_valid_q || out_ready;
  assign in_ready = advance;
  assign in_xfer  = in_valid && advance;
  assign cnt_wrap = (bin_cnt_q == LAST_BIN);
  assign len_err  = in_xfer && (in_last != cnt_wrap);

`ifdef PSPEC_HALF_EN
  localparam logic [BIN_W-1:0] HALF_BIN = BIN_W'(N_FFT / 2);
  assign keep_bin = (bin_cnt_q <= HALF_BIN);
  assign tag_last = (bin_cnt_q == HALF_BIN) || in_last;
`else
  assign keep_bin = 1'b1;
  assign tag_last = in_last || cnt_wrap;
`endif

  always_comb begin
    // NOTE: every _d starts from its held value, so no branch can leave a latch behind.
    s1_valid_d  = s1_valid_q;
    s1_re_d     = s1_re_q;
    s1_im_d     = s1_im_q;
    s1_bin_d    = s1_bin_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_re_sq_d  = s2_re_sq_q;
    s2_im_sq_d  = s2_im_sq_q;
    s2_bin_d    = s2_bin_q;
    s2_last_d   = s2_last_q;
    s3_valid_d  = s3_valid_q;
    s3_power_d  = s3_power_q;
    s3_bin_d    = s3_bin_q;
    s3_last_d   = s3_last_q;
    bin_cnt_d   = bin_cnt_q;
    frame_err_d = frame_err_q;

    if (advance) begin
      s1_valid_d = in_valid && keep_bin;
      if (in_valid && keep_bin) begin
        s1_re_d   = in_re;
        s1_im_d   = in_im;
        s1_bin_d  = bin_cnt_q;
        s1_last_d = tag_last;
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        // Sign-extend before multiplying so (-2^31)^2 = 2^62 comes out exact.
        s2_re_sq_d = 64'(s1_re_q) * 64'(s1_re_q);
        s2_im_sq_d = 64'(s1_im_q) * 64'(s1_im_q);
        s2_bin_d   = s1_bin_q;
        s2_last_d  = s1_last_q;
      end

      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_power_d = s2_re_sq_q + s2_im_sq_q;
        s3_bin_d   = s2_bin_q;
        s3_last_d  = s2_last_q;
      end
    end

    if (in_xfer) begin
      bin_cnt_d = (in_last || cnt_wrap) ? '0 : bin_cnt_q + 1'b1;
    end

    if (len_err) begin
      frame_err_d = 1'b1;
    end else if (frame_err_clr) begin
      frame_err_d = 1'b0;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, because out_power/out_bin/out_last must read 0 after reset.
      s1_valid_q  <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s1_bin_q    <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_re_sq_q  <= '0;
      s2_im_sq_q  <= '0;
      s2_bin_q    <= '0;
      s2_last_q   <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_power_q  <= '0;
      s3_bin_q    <= '0;
      s3_last_q   <= 1'b0;
      bin_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_re_q     <= s1_re_d;
      s1_im_q     <= s1_im_d;
      s1_bin_q    <= s1_bin_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_re_sq_q  <= s2_re_sq_d;
      s2_im_sq_q  <= s2_im_sq_d;
      s2_bin_q    <= s2_bin_d;
      s2_last_q   <= s2_last_d;
      s3_valid_q  <= s3_valid_d;
      s3_power_q  <= s3_power_d;
      s3_bin_q    <= s3_bin_d;
      s3_last_q   <= s3_last_d;
      bin_cnt_q   <= bin_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_power = s3_power_q;
  assign out_bin   = s3_bin_q;
  assign out_last  = s3_last_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_power_spectrum.sv
// Directed bench for power_spectrum (N_FFT = 16): literal-valued squares, framing, stalls, errors, reset.
// Honours PSPEC_HALF_EN the same way the design does when the macro is defined for both.
module tb_power_spectrum;

  localparam int N  = 16;
  localparam int BW = $clog2(N);
`ifdef PSPEC_HALF_EN
  localparam int FRAME_OUTS = N / 2 + 1;
`else
  localparam int FRAME_OUTS = N;
`endif

  typedef struct {
    logic [63:0]   power;
    logic [BW-1:0] bin;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_re = '0;
  logic [31:0]   in_im = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   out_power;
  logic [BW-1:0] out_bin;
  logic          out_last;
  logic          frame_err;
  logic          frame_err_clr = 1'b0;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   mcnt = 0;
  int   n_out = 0;
  int   n_last = 0;
  bit   rdy_toggle = 1'b0;

  power_spectrum #(.N_FFT(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_power(out_power), .out_bin(out_bin), .out_last(out_last),
    .frame_err(frame_err), .frame_err_clr(frame_err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic logic [63:0] pw(input logic [31:0] re, input logic [31:0] im);
    logic signed [63:0] r;
    logic signed [63:0] i;
    r = 64'(signed'(re));
    i = 64'(signed'(im));
    return $unsigned(r * r) + $unsigned(i * i);
  endfunction

  // Reference for what one accepted bin should produce at the output.
  task automatic model_accept(input logic [31:0] re, input logic [31:0] im, input bit last);
    exp_t e;
    bit   wrap;
    bit   emit;
    wrap = (mcnt == N - 1);
`ifdef PSPEC_HALF_EN
    emit   = (mcnt <= N / 2);
    e.last = (mcnt == N / 2) || last;
`else
    emit   = 1'b1;
    e.last = last || wrap;
`endif
    e.power = pw(re, im);
    e.bin   = BW'(mcnt);
    if (emit) exp_q.push_back(e);
    mcnt = (last || wrap) ? 0 : mcnt + 1;
  endtask

  task automatic drive_cycle(input bit v, input logic [31:0] re, input logic [31:0] im,
                             input bit last, output bit acc);
    in_valid = v;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) model_accept(re, im, last);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] re, input logic [31:0] im, input bit last);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      drive_cycle(1'b1, re, im, last, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cycle_idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && k < 100) begin
      cycle_idle();
      k++;
    end
    repeat (4) cycle_idle();
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic reset_dut();
    rdy_toggle    = 1'b0;
    out_ready     = 1'b1;
    frame_err_clr = 1'b0;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mcnt = 0;
  endtask

  // Lone bin through an empty pipe: result must appear exactly three edges after the transfer cycle.
  task automatic single(input logic [31:0] re, input logic [31:0] im,
                        input logic [63:0] expp, input int expb);
    bit acc;
    out_ready = 1'b1;
    drive_cycle(1'b1, re, im, 1'b0, acc);
    check("single_acc", 64'(acc), 64'(1));
    in_valid = 1'b0;
    check("lat_s1", 64'(out_valid), 64'(0));
    cycle_idle();
    check("lat_s2", 64'(out_valid), 64'(0));
    cycle_idle();
    check("lat_s3_valid", 64'(out_valid), 64'(1));
    check("lat_s3_power", out_power, expp);
    check("lat_s3_bin", 64'(out_bin), 64'(expb));
    check("lat_s3_last", 64'(out_last), 64'(0));
    cycle_idle();
  endtask

  // Output monitor: scoreboard order, hold-during-stall and in_ready rule.
  initial begin : monitor
    exp_t          e;
    bit            hold;
    logic [63:0]   hp;
    logic [BW-1:0] hb;
    logic          hl;
    hold = 1'b0;
    hp   = '0;
    hb   = '0;
    hl   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (hold) begin
          check("stall_valid", 64'(out_valid), 64'(1));
          check("stall_power", out_power, hp);
          check("stall_bin", 64'(out_bin), 64'(hb));
          check("stall_last", 64'(out_last), 64'(hl));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_bin", 64'(out_bin), 64'({BW{1'bx}}));
          end else begin
            e = exp_q.pop_front();
            check("sb_power", out_power, e.power);
            check("sb_bin", 64'(out_bin), 64'(e.bin));
            check("sb_last", 64'(out_last), 64'(e.last));
            n_out++;
            if (out_last) n_last++;
          end
        end
        hold = out_valid && !out_ready;
        hp   = out_power;
        hb   = out_bin;
        hl   = out_last;
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) out_ready = !out_ready;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc;
    int acc_cnt;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_power", out_power, 64'(0));
    check("rst_out_bin", 64'(out_bin), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    single(32'h4000_0000, 32'h4000_0000, 64'h2000_0000_0000_0000, 0);
    single(32'h8000_0000, 32'h8000_0000, 64'h8000_0000_0000_0000, 1);
    single(32'h7FFF_FFFF, 32'h0000_0000, 64'h3FFF_FFFF_0000_0001, 2);
    single(32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_0000_0002, 3);
    single(32'h0000_0000, 32'hC000_0000, 64'h1000_0000_0000_0000, 4);

    // Full frame back-to-back.
    reset_dut();
    n_out  = 0;
    n_last = 0;
    for (int i = 0; i < N; i++) send(32'(i * 32'h0101_0101), 32'(32'h8000_0000 + i * 7), i == N - 1);
    drain();
    check("frame_outputs", 64'(n_out), 64'(FRAME_OUTS));
    check("frame_lasts", 64'(n_last), 64'(1));
    check("frame_err_ok", 64'(frame_err), 64'(0));

    // Two frames with random input gaps while out_ready toggles every cycle.
    reset_dut();
    rdy_toggle = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      repeat ($urandom_range(0, 2)) cycle_idle();
      send($urandom(), $urandom(), (i % N) == N - 1);
    end
    drain();
    rdy_toggle = 1'b0;
    out_ready  = 1'b1;
    check("gaps_frame_err", 64'(frame_err), 64'(0));

    // Downstream blocked: exactly three bins get in, nothing lost once released.
    reset_dut();
    out_ready = 1'b0;
    acc_cnt   = 0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b1, 32'(32'h1000_0000 + acc_cnt), 32'(acc_cnt * 3), 1'b0, acc);
      if (acc) acc_cnt++;
    end
    in_valid = 1'b0;
    check("stall_accepted", 64'(acc_cnt), 64'(3));
    check("stall_in_ready", 64'(in_ready), 64'(0));
    check("stall_head_valid", 64'(out_valid), 64'(1));
    check("stall_head_bin", 64'(out_bin), 64'(0));
    out_ready = 1'b1;
    drain();

    // Short frame: in_last on bin 5.
    reset_dut();
    for (int i = 0; i < 6; i++) send(32'(i + 1), 32'(i + 2), i == 5);
    check("short_frame_err", 64'(frame_err), 64'(1));
    send(32'h0000_1000, 32'h0000_0010, 1'b0);
    cycle_idle();
    cycle_idle();
    check("restart_valid", 64'(out_valid), 64'(1));
    check("restart_bin", 64'(out_bin), 64'(0));
    drain();
    frame_err_clr = 1'b1;
    cycle_idle();
    frame_err_clr = 1'b0;
    check("clr_frame_err", 64'(frame_err), 64'(0));
    frame_err_clr = 1'b1;
    send(32'h0000_0003, 32'h0000_0004, 1'b1);
    frame_err_clr = 1'b0;
    check("set_beats_clr", 64'(frame_err), 64'(1));
    drain();

    // Long frame: bin N-1 without in_last forces the frame end.
    reset_dut();
    n_last = 0;
    for (int i = 0; i < N; i++) send(32'(32'hFFFF_0000 + i), 32'(i << 20), 1'b0);
    check("long_frame_err", 64'(frame_err), 64'(1));
    send(32'h0000_0005, 32'h0000_0000, 1'b0);
    drain();
    check("long_frame_lasts", 64'(n_last), 64'(1));

    // Reset with three bins in flight.
    reset_dut();
    for (int i = 0; i < 3; i++) send(32'(32'h0100_0000 * (i + 1)), 32'(i), 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mcnt = 0;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    for (int i = 0; i < 3; i++) begin
      cycle_idle();
      check("midrst_no_stale", 64'(out_valid), 64'(0));
    end
    send(32'h2000_0000, 32'h0000_0000, 1'b0);
    cycle_idle();
    cycle_idle();
    check("midrst_next_valid", 64'(out_valid), 64'(1));
    check("midrst_next_bin", 64'(out_bin), 64'(0));
    check("midrst_next_power", out_power, 64'h0400_0000_0000_0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
